// File: rtl/vproc_div_core.sv
// Radix-2 restoring divider for one SEW-wide element pair (VDIVU/VDIV/VREMU/VREM).
// in_op_i: bit0 = signed, bit1 = remainder. in_vsew_i: 0/1/2 = 8/16/32 bits, 3 is treated as 32.
module vproc_div_core #(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic [1:0]       in_vsew_i,
    input  logic [31:0]      in_op1_i,
    input  logic [31:0]      in_op2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_res_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              accept;
    logic [4:0]        cnt_q;
    logic [31:0]       rem_q, quo_q, div_q, mask_q, res_q;
    logic              sa_q, sb_q, sel_rem_q;
    logic [TAG_W-1:0]  tag_q;

    logic [4:0]  w_m1;
    logic [31:0] mask, msb, a_low, b_low, a_ext, b_ext, a_mag, b_mag, spec_res;
    logic        is_signed, sa, sb, div_zero, ovf, special;

    // Operand decode and special-case detection, evaluated on the request itself
    always_comb begin
        case (in_vsew_i)
            2'd0:    begin w_m1 = 5'd7;  mask = 32'h0000_00FF; msb = 32'h0000_0080; end
            2'd1:    begin w_m1 = 5'd15; mask = 32'h0000_FFFF; msb = 32'h0000_8000; end
            default: begin w_m1 = 5'd31; mask = 32'hFFFF_FFFF; msb = 32'h8000_0000; end
        endcase
        is_signed = in_op_i[0];
        a_low     = in_op1_i & mask;
        b_low     = in_op2_i & mask;
        sa        = is_signed & (|(a_low & msb));
        sb        = is_signed & (|(b_low & msb));
        a_ext     = sa ? (a_low | ~mask) : a_low;
        b_ext     = sb ? (b_low | ~mask) : b_low;
        a_mag     = sa ? (32'd0 - a_ext) : a_ext;
        b_mag     = sb ? (32'd0 - b_ext) : b_ext;
        div_zero  = (b_low == 32'd0);
        ovf       = is_signed && (a_low == msb) && (b_low == mask);
        special   = div_zero | ovf;
        if (in_op_i[1]) spec_res = div_zero ? a_low : 32'd0;
        else            spec_res = div_zero ? mask  : a_low;
    end

    logic [32:0] r_sh, diff;
    logic [31:0] rem_nx, quo_nx, q_fin, r_fin, fin_res;
    logic        ge;

    // One restoring step; diff[32] is the borrow because the remainder stays below the divisor
    always_comb begin
        r_sh    = {rem_q, quo_q[31]};
        diff    = r_sh - {1'b0, div_q};
        ge      = ~diff[32];
        rem_nx  = ge ? diff[31:0] : r_sh[31:0];
        quo_nx  = {quo_q[30:0], ge};
        q_fin   = (sa_q ^ sb_q) ? (32'd0 - quo_nx) : quo_nx;
        r_fin   = sa_q ? (32'd0 - rem_nx) : rem_nx;
        fin_res = (sel_rem_q ? r_fin : q_fin) & mask_q;
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) state_q <= IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : ITER;
            ITER:    if (cnt_q == 5'd0) state_d = DONE;
            DONE:    if (out_ready_i) state_d = accept ? (special ? DONE : ITER) : IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_comb begin
        in_ready_o  = !kill_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
    end

    assign accept = in_valid_i && in_ready_o;

    // The dividend is left-aligned in quo_q so its MSB is always shifted in first
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            mask_q    <= '0;
            res_q     <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            sel_rem_q <= 1'b0;
            tag_q     <= '0;
        end else if (accept) begin
            cnt_q     <= w_m1;
            rem_q     <= '0;
            quo_q     <= a_mag << (5'd31 - w_m1);
            div_q     <= b_mag;
            mask_q    <= mask;
            sa_q      <= sa;
            sb_q      <= sb;
            sel_rem_q <= in_op_i[1];
            tag_q     <= in_tag_i;
            if (special) res_q <= spec_res;
        end else if (state_q == ITER) begin
            cnt_q <= cnt_q - 5'd1;
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (cnt_q == 5'd0) res_q <= fin_res;
        end
    end

    assign out_res_o = res_q;
    assign out_tag_o = tag_q;
endmodule

// File: tb/tb_vproc_div_core.sv
// Directed bench for vproc_div_core: an arithmetic reference model checked every cycle,
// plus literal expectations for the documented vectors, backpressure, kill and reset.
module tb_vproc_div_core;
    localparam int TAG_W = 8;
    localparam logic [1:0] VDIVU = 2'd0, VDIV = 2'd1, VREMU = 2'd2, VREM = 2'd3;
    localparam logic [1:0] SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEWX = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'd0;
    logic [1:0]       in_vsew = 2'd0;
    logic [31:0]      in_op1 = 32'd0;
    logic [31:0]      in_op2 = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             kill = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_res;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    vproc_div_core #(.TAG_W(TAG_W)) dut (
        .clk_i(clk), .async_rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_op_i(in_op), .in_vsew_i(in_vsew), .in_op1_i(in_op1), .in_op2_i(in_op2),
        .in_tag_i(in_tag), .kill_i(kill),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_res_o(out_res), .out_tag_o(out_tag), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: signed/unsigned values as plain integers, SV truncating division and remainder
    task automatic model(input logic [1:0] op, input logic [1:0] vsew, input logic [31:0] a_in,
                         input logic [31:0] b_in, output logic [31:0] res, output int lat);
        int     w;
        longint mask, a, b, q, r;
        w    = (vsew == SEW8) ? 8 : (vsew == SEW16) ? 16 : 32;
        mask = (longint'(1) << w) - 1;
        a    = longint'(a_in) & mask;
        b    = longint'(b_in) & mask;
        if (op[0] && a >= (longint'(1) << (w - 1))) a = a - (longint'(1) << w);
        if (op[0] && b >= (longint'(1) << (w - 1))) b = b - (longint'(1) << w);
        if (b == 0) begin
            q = -1; r = a; lat = 1;
        end else if (op[0] && a == -(longint'(1) << (w - 1)) && b == -1) begin
            q = a; r = 0; lat = 1;
        end else begin
            q = a / b; r = a % b; lat = w + 1;
        end
        res = 32'((op[1] ? r : q) & mask);
    endtask

    // Per-cycle compare against the head of the expectation queue
    always @(negedge clk) begin : mon
        bit due;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                due = (cyc >= exp_q[0].acc + exp_q[0].lat);
                chk("valid_timing", out_valid, due);
                if (due && out_valid) begin
                    chk("model_res", out_res, exp_q[0].res);
                    chk("model_tag", out_tag, exp_q[0].tag);
                    if (out_ready && !kill) void'(exp_q.pop_front());
                end
            end else begin
                chk("valid_idle", out_valid, 1'b0);
            end
            if (kill) exp_q.delete();
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] vsew, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        bit   ok;
        in_op = op; in_vsew = vsew; in_op1 = a; in_op2 = b; in_tag = tag; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        else begin
            model(op, vsew, a, b, e.res, e.lat);
            e.tag = tag;
            e.acc = cyc;
            last_acc = cyc;
            exp_q.push_back(e);
            $display("issue op=%0d vsew=%0d a=0x%08h b=0x%08h tag=0x%02h exp=0x%08h cycle=%0d",
                     op, vsew, a, b, tag, e.res, cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = cyc - last_acc; break; end
        end
        if (lat < 0) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_lit(input string name, input logic [1:0] op, input logic [1:0] vsew,
                           input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                           input logic [31:0] lit, input int lit_lat);
        int seen;
        out_ready = 1'b1;
        issue(op, vsew, a, b, tag);
        wait_valid(seen);
        chk({name, "_res"}, out_res, lit);
        chk({name, "_lat"}, seen, lit_lat);
        $display("result %s res=0x%08h lat=%0d", name, out_res, seen);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        int          l, seen, c0;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_res", out_res, 32'd0);
        chk("rst_tag", out_tag, 32'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        model(VDIVU, SEW32, 32'd100, 32'd7, r, l);
        chk("pin_divu", r, 32'd14);
        chk("pin_divu_lat", l, 33);
        model(VREM, SEW8, 32'hF9, 32'h02, r, l);
        chk("pin_rem8", r, 32'hFF);
        model(VDIV, SEW32, 32'h8000_0000, 32'hFFFF_FFFF, r, l);
        chk("pin_ovf", r, 32'h8000_0000);
        chk("pin_ovf_lat", l, 1);

        run_lit("divu32", VDIVU, SEW32, 32'd100, 32'd7, 8'h01, 32'd14, 33);
        run_lit("remu32", VREMU, SEW32, 32'd100, 32'd7, 8'h02, 32'd2, 33);
        run_lit("div8",   VDIV,  SEW8,  32'hABCD_EFF9, 32'h1234_5602, 8'h03, 32'h0000_00FD, 9);
        run_lit("rem8",   VREM,  SEW8,  32'hABCD_EFF9, 32'h1234_5602, 8'h04, 32'h0000_00FF, 9);
        run_lit("dz_divu16", VDIVU, SEW16, 32'h0000_1234, 32'd0, 8'h05, 32'h0000_FFFF, 1);
        run_lit("dz_rem16",  VREM,  SEW16, 32'h0000_1234, 32'd0, 8'h06, 32'h0000_1234, 1);
        run_lit("ovf_div32", VDIV,  SEW32, 32'h8000_0000, 32'hFFFF_FFFF, 8'h07, 32'h8000_0000, 1);
        run_lit("ovf_rem32", VREM,  SEW32, 32'h8000_0000, 32'hFFFF_FFFF, 8'h08, 32'd0, 1);
        run_lit("ovf_div8",  VDIV,  SEW8,  32'h0000_0080, 32'h0000_00FF, 8'h09, 32'h0000_0080, 1);
        run_lit("divx",      VDIV,  SEWX,  32'hFFFF_FF9C, 32'd7, 8'h0A, 32'hFFFF_FFF2, 33);
        run_lit("rem16neg",  VREM,  SEW16, 32'h0000_FF9C, 32'h0000_FFF9, 8'h0B, 32'h0000_FFFE, 17);
        run_lit("divu8max",  VDIVU, SEW8,  32'h0000_00FF, 32'd1, 8'h0C, 32'h0000_00FF, 9);

        // Backpressure in DONE, then a same-cycle handshake and accept
        out_ready = 1'b0;
        issue(VDIV, SEW8, 32'h0000_00F9, 32'h0000_0002, 8'h5A);
        wait_valid(seen);
        chk("hold_lat", seen, 9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_res", out_res, 32'h0000_00FD);
            chk("hold_tag", out_tag, 32'h5A);
            chk("hold_ready", in_ready, 1'b0);
            chk("hold_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        c0 = cyc;
        out_ready = 1'b1;
        issue(VDIVU, SEW8, 32'd200, 32'd9, 8'h5B);
        chk("b2b_accept_cycle", last_acc, c0);
        wait_valid(seen);
        chk("b2b_res", out_res, 32'd22);
        chk("b2b_tag", out_tag, 32'h5B);
        chk("b2b_lat", seen, 9);
        $display("result b2b res=0x%08h lat=%0d", out_res, seen);
        @(posedge clk); #1;

        // Kill in ITER cycle 5 while a special-case request is offered
        issue(VDIVU, SEW32, 32'd1000, 32'd3, 8'h11);
        repeat (4) @(posedge clk);
        #1;
        chk("kill_busy_pre", busy, 1'b1);
        kill = 1'b1; in_valid = 1'b1;
        in_op = VDIVU; in_vsew = SEW8; in_op1 = 32'd5; in_op2 = 32'd0; in_tag = 8'h22;
        @(negedge clk);
        chk("kill_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        chk("kill_busy", busy, 1'b0);
        chk("kill_valid", out_valid, 1'b0);
        $display("kill applied cycle=%0d", cyc);
        repeat (40) @(posedge clk);
        #1;

        // Asynchronous reset mid-iteration
        issue(VDIV, SEW16, 32'h0000_FF9C, 32'h0000_FFF9, 8'h77);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", in_ready, 1'b1);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_res", out_res, 32'd0);
        chk("arst_tag", out_tag, 32'd0);
        chk("arst_busy", busy, 1'b0);
        $display("reset applied cycle=%0d", cyc);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        run_lit("post_rst", VREMU, SEW16, 32'd1000, 32'd7, 8'h33, 32'd6, 17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vproc_div_core.md
# vproc_div_core

Iterative per-element integer divider that executes the `opcode_div` operations (VDIVU, VDIV, VREMU, VREM) issued to `UNIT_DIV`. It sits inside the vector divide unit, downstream of operand unpacking and upstream of result packing. It accepts one element pair per transaction under SEW 8/16/32 and produces one SEW-wide result using RISC-V division semantics. It computes one quotient bit per cycle with radix-2 restoring division.

## Interface
Parameters:
- `TAG_W`, default 8: width of the opaque tag that passes from input to output unchanged, for example the element index and the last flag.

Ports:
- `clk_i`  in  1  clock
- `async_rst_ni`  in  1  asynchronous active-low reset
- `in_valid_i`  in  1  operation request
- `in_ready_o`  out  1  core can accept a request
- `in_op_i`  in  2  `opcode_div`
- `in_vsew_i`  in  2  `cfg_vsew`; VSEW_INVALID is treated as VSEW_32
- `in_op1_i`  in  32  dividend (vs2); low SEW bits are used
- `in_op2_i`  in  32  divisor (vs1/rs1); low SEW bits are used
- `in_tag_i`  in  TAG_W  tag
- `kill_i`  in  1  synchronous abort of any in-flight operation
- `out_valid_o`  out  1  result valid
- `out_ready_i`  in  1  consumer accepts the result
- `out_res_o`  out  32  result in the low SEW bits; upper bits are zero
- `out_tag_o`  out  TAG_W  tag of the result
- `busy_o`  out  1  state is not IDLE

## Operation
- States:
  - IDLE: waiting for a request.
  - ITER: iterating; a counter runs from W-1 down to 0, where W = 8/16/32 from SEW.
  - DONE: holding the result.
- Accept condition: `in_valid_i && in_ready_o`. On accept, latch op, W, operands and tag.
- `in_ready_o` = !`kill_i` && (IDLE || (DONE && `out_ready_i`)). This allows back-to-back operation.
- Operand extension:
  - VDIV/VREM: sign-extend from bit W-1. The sign flags are sa = dividend sign and sb = divisor sign.
  - VDIVU/VREMU: zero-extend; sa = sb = 0.
- Iteration: operate on magnitudes |a| and |b|. Each cycle, shift the partial remainder left by one, bringing in the next dividend bit, and trial-subtract |b|. If the difference is non-negative, keep it and set the quotient bit to 1; otherwise keep the partial remainder and set the quotient bit to 0.
- Finalisation:
  - Negate the quotient if sa XOR sb.
  - The remainder takes the sign of the dividend (negate if sa).
  - Truncate the result to W bits.
- Special cases are decided at accept, skip ITER and go directly to DONE:
  - Divisor == 0: quotient = all ones (W bits); remainder = dividend.
  - Signed overflow (dividend = -2^(W-1) and divisor = -1): quotient = dividend; remainder = 0.
- Result select: VDIVU/VDIV output the quotient; VREMU/VREM output the remainder.
- DONE holds `out_res_o` and `out_tag_o` stable until `out_valid_o && out_ready_i`. It then goes to IDLE, or to ITER/DONE if a new accept happens in the same cycle.
- `kill_i` has priority over everything:
  - Next state is IDLE, `out_valid_o` deasserts the next cycle, and the result is discarded.
  - No accept occurs in the kill cycle.

## Timing
- Reset values: state IDLE; `in_ready_o` = 1 (when `kill_i` = 0); `out_valid_o` = 0; `out_res_o` = 0; `out_tag_o` = 0; `busy_o` = 0.
- Reset mid-operation aborts immediately; no result is ever produced for that operation.
- Normal latency: accept in cycle 0, ITER in cycles 1..W, finalise on the last ITER edge, `out_valid_o` high from cycle W+1. That is 9, 17 or 33 cycles for SEW 8/16/32.
- Special-case latency: `out_valid_o` high in cycle 1.
- Throughput: one result per W+1 cycles with back-to-back accept in DONE. Special cases give one result per cycle.
- `out_valid_o` is registered. Once high it stays high, with the result stable, until the handshake or `kill_i`.
- `in_ready_o` depends combinationally on `out_ready_i` and `kill_i`. No other combinational input-to-output paths exist.

## Test plan
- VDIVU, SEW 32, op1 = 100, op2 = 7 -> `out_res_o` = 14 at cycle 33; VREMU on the same operands -> 2.
- VDIV, SEW 8, op1 = 0xF9 (-7), op2 = 0x02 -> `out_res_o` = 0x000000FD (-3) at cycle 9; VREM -> 0x000000FF (-1). Upper 24 bits are zero even with garbage in the upper input bits.
- Divide by zero: VDIVU SEW 16, op1 = 0x1234, op2 = 0 -> 0x0000FFFF at cycle 1. VREM on the same operands -> 0x00001234.
- Overflow: VDIV SEW 32, op1 = 0x80000000, op2 = 0xFFFFFFFF -> 0x80000000 at cycle 1; VREM -> 0.
- Backpressure and back-to-back:
  - Hold `out_ready_i` = 0 for 5 cycles in DONE -> result and tag stay stable, `in_ready_o` = 0.
  - Raise `out_ready_i` with a new `in_valid_i` -> both handshakes occur in the same cycle, and the second result appears W+1 cycles later.
- Kill and reset:
  - Assert `kill_i` in ITER cycle 5 with `in_valid_i` = 1 -> no accept, `out_valid_o` never rises, `busy_o` = 0 the next cycle.
  - Deassert `async_rst_ni` mid-ITER -> all outputs return to their reset values immediately.
